msx_slot_mapper: RTL

Cartridge-side ASCII8 megaROM mapper and slot responder that consumes the MSX bus cycles produced by the MAX II bus master. It synchronises the asynchronous MSX strobes and tracks four 8 KiB bank registers written through the mapper window. For each slot read it drives a 21-bit flash address, holds the bus with WAIT for a fixed number of flash access cycles, then returns the flash byte. It sits between the MSX connector (ADDR/DATA/strobes) and the parallel flash device.

---
 rtl/msx_slot_mapper.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/msx_slot_mapper.sv
// msx_slot_mapper
//   ASCII8 megaROM mapper and slot responder for an MSX cartridge.
//   It synchronises the asynchronous MSX strobes and keeps four 8 KiB bank
//   registers, which are written through the 6000-7FFF window. On a slot read
//   in 4000-BFFF it drives the flash address and holds WAIT_n low for
//   WAIT_CYCLES cycles. It then returns the flash byte and keeps it on the bus
//   until the CPU ends the read cycle.
//
// Ports
//   CLK, RESET                   clock, synchronous active-high reset
//   ADDR[15:0], DATA_IN[7:0]     MSX address / inbound data
//   DATA_OUT[7:0], DATA_OE       MSX outbound data and its output enable
//   SLTSL_n, MREQ_n, RD_n, WR_n  asynchronous active-low MSX strobes
//   WAIT_n                       MSX wait request (open-drain at top level)
//   FA[20:0], FD[7:0]            flash address / flash data
//   FCE_n, FOE_n                 flash chip enable / output enable
module msx_slot_mapper #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic [7:0]  DATA_IN,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_OE,
  input  logic        SLTSL_n,
  input  logic        MREQ_n,
  input  logic        RD_n,
  input  logic        WR_n,
  output logic        WAIT_n,
  output logic [20:0] FA,
  input  logic [7:0]  FD,
  output logic        FCE_n,
  output logic        FOE_n
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_HOLD = 3'd2,
    WR_DONE = 3'd3,
    IGNORE  = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  // Strobe synchronisers: _p0 is the capture flop, _p1 is the FSM-facing copy
  logic sltsl_p0, sltsl_p1;
  logic mreq_p0,  mreq_p1;
  logic rd_p0,    rd_p1;
  logic wr_p0,    wr_p1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sltsl_p0 <= 1'b1;
      sltsl_p1 <= 1'b1;
      mreq_p0  <= 1'b1;
      mreq_p1  <= 1'b1;
      rd_p0    <= 1'b1;
      rd_p1    <= 1'b1;
      wr_p0    <= 1'b1;
      wr_p1    <= 1'b1;
    end else begin
      sltsl_p0 <= SLTSL_n;
      sltsl_p1 <= sltsl_p0;
      mreq_p0  <= MREQ_n;
      mreq_p1  <= mreq_p0;
      rd_p0    <= RD_n;
      rd_p1    <= rd_p0;
      wr_p0    <= WR_n;
      wr_p1    <= wr_p0;
    end
  end

  // Synchronised strobes feed the FSM and the registered outputs
  logic       sel;
  logic       rd_win;
  logic       wr_win;
  logic [1:0] idx;

  assign sel    = ~sltsl_p1 & ~mreq_p1;
  assign rd_win = (ADDR[15:13] >= 3'd2) && (ADDR[15:13] <= 3'd5);
  assign wr_win = (ADDR[15:13] == 3'd3);
  // ADDR[15:13]-2 truncated to two bits equals ADDR[14:13]-2 modulo 4
  // for the four read windows (2..5 -> 0..3).
  assign idx    = ADDR[14:13] - 2'd2;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [7:0]  bank [0:3];
  logic        bank_we;
  logic [20:0] fa_nx;
  logic [7:0]  dout_nx;
  logic        oe_nx, wait_nx, fce_nx, foe_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fa_nx    = FA;
    dout_nx  = DATA_OUT;
    oe_nx    = DATA_OE;
    wait_nx  = WAIT_n;
    fce_nx   = FCE_n;
    foe_nx   = FOE_n;
    bank_we  = 1'b0;

    case (state)
      IDLE: begin
        oe_nx   = 1'b0;
        wait_nx = 1'b1;
        fce_nx  = 1'b1;
        foe_nx  = 1'b1;
        if (sel && (!rd_p1 || !wr_p1)) begin
          if (!rd_p1 && wr_p1 && rd_win) begin
            state_nx = RD_WAIT;
            fa_nx    = {bank[idx], ADDR[12:0]};
            fce_nx   = 1'b0;
            foe_nx   = 1'b0;
            wait_nx  = 1'b0;
            cnt_nx   = CNT_LOAD;
          end else if (!wr_p1 && rd_p1 && wr_win) begin
            state_nx = WR_DONE;
            bank_we  = 1'b1;
          end else begin
            state_nx = IGNORE;
          end
        end
      end

      RD_WAIT: begin
        // An abort wins over counter expiry, so a cycle the CPU has already
        // ended never puts data on the bus.
        if (rd_p1 || sltsl_p1) begin
          state_nx = IDLE;
          wait_nx  = 1'b1;
          fce_nx   = 1'b1;
          foe_nx   = 1'b1;
          oe_nx    = 1'b0;
        end else if (cnt == 4'd0) begin
          state_nx = RD_HOLD;
          dout_nx  = FD;
          oe_nx    = 1'b1;
          wait_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end

      RD_HOLD: begin
        if (rd_p1 || sltsl_p1) begin
          state_nx = IDLE;
          oe_nx    = 1'b0;
          fce_nx   = 1'b1;
          foe_nx   = 1'b1;
        end
      end

      WR_DONE, IGNORE: begin
        if (rd_p1 && wr_p1) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      FA       <= 21'd0;
      DATA_OUT <= 8'h00;
      DATA_OE  <= 1'b0;
      WAIT_n   <= 1'b1;
      FCE_n    <= 1'b1;
      FOE_n    <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      FA       <= fa_nx;
      DATA_OUT <= dout_nx;
      DATA_OE  <= oe_nx;
      WAIT_n   <= wait_nx;
      FCE_n    <= fce_nx;
      FOE_n    <= foe_nx;
    end
  end

  // Bank registers; ADDR[12:11] selects 6000/6800/7000/7800
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
    end else if (bank_we) begin
      bank[ADDR[12:11]] <= DATA_IN;
    end
  end

endmodule
